// File: rtl/my_nios2_system_sysid_arbiter.sv
// my_nios2_system_sysid_arbiter: round-robin arbiter sharing one sysid slave between two read-only masters.
// Optional SYSID_ARB_CHECK_EN adds a sticky id_mismatch flag comparing captured words to EXPECTED_ID/EXPECTED_TS.
module my_nios2_system_sysid_arbiter #(
   parameter logic [31:0] EXPECTED_ID = 32'h00000000,
   parameter logic [31:0] EXPECTED_TS = 32'd1417920494
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        m0_read,
   input  logic        m0_address,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic        m1_read,
   input  logic        m1_address,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic        s_address,
   input  logic [31:0] s_readdata
`ifdef SYSID_ARB_CHECK_EN
   ,
   output logic        id_mismatch
`endif
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_grant_q, last_grant_d;
   logic [31:0] data_q, data_d;
   logic        gnt_read, gnt_addr;
   // Next state: arbitrate in IDLE; last_grant only moves on a real acceptance so an aborted grant keeps fairness.
   always_comb begin
      gnt_read     = grant_q ? m1_read : m0_read;
      gnt_addr     = grant_q ? m1_address : m0_address;
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      data_d       = data_q;
      case (state_q)
         IDLE: begin
            if (m0_read | m1_read) begin
               grant_d = (m0_read & m1_read) ? ~last_grant_q : m1_read;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (gnt_read) begin
               data_d       = s_readdata;
               last_grant_d = grant_q;
               state_d      = RESP;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // Master-facing outputs: stall every requester except the one being accepted this cycle.
   always_comb begin
      s_address        = (state_q == ISSUE) ? gnt_addr : 1'b0;
      m0_waitrequest   = m0_read & ~((state_q == ISSUE) & ~grant_q);
      m1_waitrequest   = m1_read & ~((state_q == ISSUE) & grant_q);
      m0_readdatavalid = (state_q == RESP) & ~grant_q;
      m1_readdatavalid = (state_q == RESP) & grant_q;
      m0_readdata      = data_q;
      m1_readdata      = data_q;
   end
   // State register; master 0 wins the first contention after reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         data_q       <= 32'h0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         data_q       <= data_d;
      end
   end
`ifdef SYSID_ARB_CHECK_EN
   logic mismatch_q, mismatch_d;
   // Compare the word being captured against the value expected at its address; flag sticks until reset.
   always_comb begin
      mismatch_d = mismatch_q | ((state_q == ISSUE) & gnt_read &
                   (s_readdata != (gnt_addr ? EXPECTED_TS : EXPECTED_ID)));
   end
   // Sticky mismatch register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) mismatch_q <= 1'b0;
      else          mismatch_q <= mismatch_d;
   end
   assign id_mismatch = mismatch_q;
`endif
endmodule

// File: tb/tb_my_nios2_system_sysid_arbiter.sv
// tb_my_nios2_system_sysid_arbiter: directed and random checks against a transaction-level reference model.
module tb_my_nios2_system_sysid_arbiter;
   localparam logic [31:0] ID = 32'h00000000;
   localparam logic [31:0] TS = 32'd1417920494;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        m0_read = 1'b0, m0_address = 1'b0, m1_read = 1'b0, m1_address = 1'b0;
   logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, s_address;
   logic [31:0] m0_readdata, m1_readdata;
   logic [31:0] s_readdata = 32'h0;
`ifdef SYSID_ARB_CHECK_EN
   logic        id_mismatch;
`endif
   my_nios2_system_sysid_arbiter dut (
      .clock(clock), .reset_n(reset_n),
      .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_readdata(s_readdata)
`ifdef SYSID_ARB_CHECK_EN
      , .id_mismatch(id_mismatch)
`endif
   );
   always #5 clock = ~clock;
   int errs = 0, checks = 0, nvalid = 0, nboth = 0;
   // Reference model: age of the in-flight transaction (-1 free, 0 accept cycle, 1 response cycle).
   int          age;
   bit          own, last, mmis;
   logic [31:0] mdata;
   logic [1:0]  acc;
   task automatic mreset();
      age = -1; own = 1'b0; last = 1'b1; mdata = 32'h0; mmis = 1'b0; acc = 2'b00;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask
   // One clock cycle: inputs already driven after a negedge; check, advance model, cross posedge.
   task automatic cycle();
      logic [1:0] rd, ad;
      #1;
      if (!reset_n) mreset();
      rd = {m1_read, m0_read};
      ad = {m1_address, m0_address};
      chk("m0_waitrequest", {31'b0, m0_waitrequest}, {31'b0, rd[0] & !(age == 0 && own == 1'b0)});
      chk("m1_waitrequest", {31'b0, m1_waitrequest}, {31'b0, rd[1] & !(age == 0 && own == 1'b1)});
      chk("m0_readdatavalid", {31'b0, m0_readdatavalid}, {31'b0, age == 1 && own == 1'b0});
      chk("m1_readdatavalid", {31'b0, m1_readdatavalid}, {31'b0, age == 1 && own == 1'b1});
      chk("s_address", {31'b0, s_address}, {31'b0, (age == 0) ? ad[own] : 1'b0});
      chk("m0_readdata", m0_readdata, mdata);
      chk("m1_readdata", m1_readdata, mdata);
`ifdef SYSID_ARB_CHECK_EN
      chk("id_mismatch", {31'b0, id_mismatch}, {31'b0, mmis});
`endif
      if (m0_readdatavalid | m1_readdatavalid) nvalid++;
      if (m0_readdatavalid & m1_readdatavalid) nboth++;
      acc = 2'b00;
      if (reset_n) begin
         if (age < 0) begin
            if (|rd) begin
               own = (rd == 2'b11) ? !last : rd[1];
               age = 0;
            end
         end else if (age == 0) begin
            if (rd[own]) begin
               acc[own] = 1'b1;
               mdata = s_readdata;
               last = own;
               mmis = mmis | (s_readdata != (ad[own] ? TS : ID));
               age = 1;
            end else begin
               age = -1;
            end
         end else begin
            age = -1;
         end
      end
      @(posedge clock);
      @(negedge clock);
   endtask
   initial begin
      logic [1:0] rq, ra;
      mreset();
      @(negedge clock);
      cycle();
      cycle();
      reset_n = 1'b1;
      // Single read of the timestamp by master 0.
      m0_read = 1'b1; m0_address = 1'b1; s_readdata = TS;
      cycle();
      cycle();
      m0_read = 1'b0; s_readdata = 32'h0;
      cycle();
      cycle();
      // Simultaneous requests after reset: master 0 first, then master 1.
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      m0_read = 1'b1; m0_address = 1'b0; m1_read = 1'b1; m1_address = 1'b1; s_readdata = ID;
      cycle();
      cycle();
      m0_read = 1'b0;
      cycle();
      s_readdata = TS;
      cycle();
      cycle();
      m1_read = 1'b0;
      cycle();
      cycle();
      // Both held for 12 cycles: four alternating strobes, never two at once.
      nvalid = 0; nboth = 0;
      m0_read = 1'b1; m1_read = 1'b1; s_readdata = 32'hA5A5_0001;
      for (int i = 0; i < 12; i++) begin
         s_readdata = s_readdata + 32'd1;
         cycle();
      end
      m0_read = 1'b0; m1_read = 1'b0;
      chk("valid_count_12", nvalid, 32'd4);
      chk("both_valid_cycles", nboth, 32'd0);
      cycle();
      // Reset during ISSUE discards the transaction; the next m1 read proceeds normally.
      m0_read = 1'b1; m0_address = 1'b0; s_readdata = 32'h1234_5678;
      cycle();
      reset_n = 1'b0; m0_read = 1'b0;
      cycle();
      reset_n = 1'b1;
      m1_read = 1'b1; m1_address = 1'b1; s_readdata = TS;
      cycle();
      cycle();
      m1_read = 1'b0;
      cycle();
      cycle();
      // m1 drops read in ISSUE while m0 waits; m0 is then served.
      m1_read = 1'b1; m1_address = 1'b0;
      cycle();
      m1_read = 1'b0; m0_read = 1'b1; m0_address = 1'b1; s_readdata = 32'hDEAD_BEEF;
      cycle();
      cycle();
      s_readdata = TS;
      cycle();
      m0_read = 1'b0;
      cycle();
      cycle();
      // Wrong ID word sets the sticky flag; a later correct read leaves it set.
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      m0_read = 1'b1; m0_address = 1'b0; s_readdata = 32'h1;
      cycle();
      cycle();
      m0_read = 1'b0; s_readdata = ID;
      cycle();
      m1_read = 1'b1; m1_address = 1'b0;
      cycle();
      cycle();
      m1_read = 1'b0;
      cycle();
      cycle();
      // Random legal traffic: a raised read is held with a stable address until accepted.
      rq = 2'b00; ra = 2'b00;
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (!(rq[k] && !acc[k])) begin
               rq[k] = 1'($urandom_range(0, 1));
               ra[k] = 1'($urandom_range(0, 1));
            end
         end
         m0_read = rq[0]; m0_address = ra[0];
         m1_read = rq[1]; m1_address = ra[1];
         case ($urandom_range(0, 3))
            0: s_readdata = ID;
            1: s_readdata = TS;
            default: s_readdata = $urandom;
         endcase
         if (i == 300) begin
            reset_n = 1'b0;
            rq = 2'b00;
            m0_read = 1'b0; m1_read = 1'b0;
         end else begin
            reset_n = 1'b1;
         end
         cycle();
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
